// File: rtl/slavefifo2b_streamin_buf_if.sv
// slavefifo2b_streamin_buf_if
// Bundles the upstream stream handshake and the FX3 slave-FIFO write side
// of the stream-in buffer. The slave modport is the buffer's view; the
// master modport is the view of whatever surrounds it (upstream source,
// flag registers and write mux).
interface slavefifo2b_streamin_buf_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        flaga_d;
    logic        flagb_d;
    logic        slwr_out_;
    logic        pktend_out_;
    logic [31:0] data_out;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        output flaga_d,
        output flagb_d,
        input  in_ready,
        input  slwr_out_,
        input  pktend_out_,
        input  data_out
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        input  flaga_d,
        input  flagb_d,
        output in_ready,
        output slwr_out_,
        output pktend_out_,
        output data_out
    );
endinterface

// File: rtl/slavefifo2b_streamin_buf.sv
// slavefifo2b_streamin_buf
// Stream-in buffer for an FX3 slave FIFO: upstream words ({last, data}) are
// queued in a 16-deep FIFO and drained toward the FX3 write mux whenever the
// registered full/watermark flags both report room. Each pop produces one
// registered active-low write strobe, with a packet-end strobe on the same
// cycle when the popped word closes a packet.
// Optional feature macro: STREAMIN_BUF_CNT_EN enables the written-word and
// packet-end counters; without it both counter outputs are tied to zero.
module slavefifo2b_streamin_buf (
    input  logic                             clk_100,
    input  logic                             reset,
    input  logic                             enable,
    slavefifo2b_streamin_buf_if.slave        bus,
    output logic [4:0]                       fifo_level,
    output logic [31:0]                      tx_word_cnt,
    output logic [15:0]                      tx_pkt_cnt
);

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;
    localparam int LVL_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Storage: bit DATA_W carries the end-of-packet marker.
    logic [DATA_W:0]      mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;

    logic                 slwr_q, slwr_d;
    logic                 pktend_q, pktend_d;
    logic [DATA_W-1:0]    data_q, data_d;

    logic                 flags_ok;
    logic                 not_empty;
    logic                 not_full;
    logic                 push;
    logic                 pop;
    logic [DATA_W:0]      head_word;

    // Handshake and transfer qualifiers. A pop only depends on the
    // registered state and level, so an entry pushed this cycle is never
    // popped in the same cycle.
    assign flags_ok     = bus.flaga_d & bus.flagb_d;
    assign not_empty    = (level_q != '0);
    assign not_full     = (level_q < LVL_W'(DEPTH));
    assign bus.in_ready = enable & ~reset & not_full;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = (state_q == WRITE) & flags_ok & not_empty;
    assign head_word    = mem_q[rd_ptr_q];

    // Next-state logic for the drain controller; dropping enable wins over
    // every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flags_ok && not_empty) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!flags_ok || (!not_empty && !push)) begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!enable) begin
            state_d = IDLE;
        end
    end

    // Pointer and occupancy bookkeeping; a disabled block flushes everything
    // on the following edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        if (!enable) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    // Write-side outputs for the next cycle: strobes idle high, data holds
    // its previous value unless a word is popped.
    always_comb begin
        slwr_d   = 1'b1;
        pktend_d = 1'b1;
        data_d   = data_q;
        if (pop) begin
            slwr_d   = 1'b0;
            pktend_d = ~head_word[DATA_W];
            data_d   = head_word[DATA_W-1:0];
        end
    end

    // FSM state, pointers and occupancy registers.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Registered write-mux outputs; reset parks the strobes inactive and
    // clears the data word so no stale packet end can leak out.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            slwr_q   <= 1'b1;
            pktend_q <= 1'b1;
            data_q   <= '0;
        end else begin
            slwr_q   <= slwr_d;
            pktend_q <= pktend_d;
            data_q   <= data_d;
        end
    end

    // FIFO storage: plain data, written on every accepted upstream word.
    always_ff @(posedge clk_100) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_last, bus.in_data};
        end
    end

    assign bus.slwr_out_   = slwr_q;
    assign bus.pktend_out_ = pktend_q;
    assign bus.data_out    = data_q;
    assign fifo_level      = level_q;

`ifdef STREAMIN_BUF_CNT_EN
    logic [31:0] word_cnt_q;
    logic [15:0] pkt_cnt_q;

    // Free-running transfer statistics, cleared only by reset and
    // wrapping at full scale.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (pop) begin
                word_cnt_q <= word_cnt_q + 32'd1;
            end
            if (pop && head_word[DATA_W]) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign tx_word_cnt = word_cnt_q;
    assign tx_pkt_cnt  = pkt_cnt_q;
`else
    assign tx_word_cnt = '0;
    assign tx_pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_slavefifo2b_streamin_buf.sv
// Testbench for slavefifo2b_streamin_buf. A reference model (a queue of
// {last, data} entries) tracks what the buffer must hold; every observed
// write strobe is checked against the head of that queue. Scenario tasks
// add directed checks on top of the continuous model comparison.
module tb_slavefifo2b_streamin_buf;

    logic        clk_100 = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic [4:0]  fifo_level;
    logic [31:0] tx_word_cnt;
    logic [15:0] tx_pkt_cnt;

    slavefifo2b_streamin_buf_if bus ();

    slavefifo2b_streamin_buf dut (
        .clk_100     (clk_100),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .fifo_level  (fifo_level),
        .tx_word_cnt (tx_word_cnt),
        .tx_pkt_cnt  (tx_pkt_cnt)
    );

    always #5 clk_100 = ~clk_100;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    logic [32:0] mq [$];
    bit          mon_en     = 1'b0;
    bit          rst_seen   = 1'b0;
    bit          flags_seen = 1'b0;
    bit          flush_seen = 1'b0;
    logic [31:0] last_data  = 32'd0;
    logic [31:0] words_wr   = 32'd0;
    logic [15:0] pkts_wr    = 16'd0;
    logic [32:0] ent;
    logic [4:0]  exp_lvl;
    logic        exp_rdy;

    // Observed writes and accepted words, for the scenario tasks
    int          obs_cyc  [$];
    logic [31:0] obs_data [$];
    bit          obs_last [$];
    logic [31:0] sent_data [$];

    // Model update at each rising edge from the inputs the DUT sees there.
    initial forever begin
        @(posedge clk_100);
        rst_seen   = reset;
        flags_seen = bus.flaga_d && bus.flagb_d;
        flush_seen = !enable;
        if (reset) begin
            mon_en = 1'b1;
            mq.delete();
        end else if (enable && bus.in_valid && mq.size() < 16) begin
            mq.push_back({bus.in_last, bus.in_data});
        end
    end

    // Output comparison mid-cycle.
    initial forever begin
        @(negedge clk_100);
        cyc++;
        if (mon_en) begin
            if (rst_seen) begin
                checks++;
                if (bus.slwr_out_ !== 1'b1 || bus.pktend_out_ !== 1'b1 || bus.data_out !== 32'd0 || fifo_level !== 5'd0) begin
                    errors++;
                    $display("FAIL reset_outputs: slwr=%b pktend=%b data=%h level=%0d, required 1 1 00000000 0",
                             bus.slwr_out_, bus.pktend_out_, bus.data_out, fifo_level);
                end
                last_data = 32'd0;
                words_wr  = 32'd0;
                pkts_wr   = 16'd0;
            end else if (bus.slwr_out_ === 1'b0) begin
                checks++;
                if (!flags_seen) begin
                    errors++;
                    $display("FAIL write_gating: slwr=0 at cycle %0d although a flag was low, required slwr=1", cyc);
                end
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL write_empty: slwr=0 data=%h at cycle %0d, required no write (model empty)", bus.data_out, cyc);
                end else begin
                    ent = mq.pop_front();
                    checks++;
                    if (bus.data_out !== ent[31:0] || bus.pktend_out_ !== ~ent[32]) begin
                        errors++;
                        $display("FAIL write_word: data=%h pktend=%b, required data=%h pktend=%b",
                                 bus.data_out, bus.pktend_out_, ent[31:0], ~ent[32]);
                    end
                    last_data = ent[31:0];
                    words_wr  = words_wr + 32'd1;
                    if (ent[32]) pkts_wr = pkts_wr + 16'd1;
                    obs_cyc.push_back(cyc);
                    obs_data.push_back(ent[31:0]);
                    obs_last.push_back(ent[32]);
                end
            end else begin
                checks++;
                if (bus.slwr_out_ !== 1'b1 || bus.pktend_out_ !== 1'b1 || bus.data_out !== last_data) begin
                    errors++;
                    $display("FAIL idle_outputs: slwr=%b pktend=%b data=%h, required 1 1 %h",
                             bus.slwr_out_, bus.pktend_out_, bus.data_out, last_data);
                end
            end
            if (flush_seen) mq.delete();
            exp_lvl = 5'(mq.size());
            checks++;
            if (fifo_level !== exp_lvl) begin
                errors++;
                $display("FAIL level: fifo_level=%0d at cycle %0d, required %0d", fifo_level, cyc, exp_lvl);
            end
            exp_rdy = enable && !reset && (mq.size() < 16);
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready: in_ready=%b at cycle %0d, required %b", bus.in_ready, cyc, exp_rdy);
            end
`ifdef STREAMIN_BUF_CNT_EN
            checks++;
            if (tx_word_cnt !== words_wr || tx_pkt_cnt !== pkts_wr) begin
                errors++;
                $display("FAIL counters: words=%0d pkts=%0d, required %0d %0d", tx_word_cnt, tx_pkt_cnt, words_wr, pkts_wr);
            end
`else
            checks++;
            if (tx_word_cnt !== 32'd0 || tx_pkt_cnt !== 16'd0) begin
                errors++;
                $display("FAIL counters_off: words=%0d pkts=%0d, required 0 0", tx_word_cnt, tx_pkt_cnt);
            end
`endif
        end
    end

    // Offer one word and hold it until accepted (called and returning just
    // after a rising edge).
    task automatic send(input logic [31:0] d, input logic l);
        bit acc;
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk_100); #1;
            acc = bus.in_ready;
            @(posedge clk_100); #1;
            if (acc) done = 1'b1;
        end
        bus.in_valid = 1'b0;
        if (done) begin
            sent_data.push_back(d);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted within 60 cycles, required acceptance", d);
        end
    endtask

    task automatic clear_logs();
        obs_cyc.delete();
        obs_data.delete();
        obs_last.delete();
        sent_data.delete();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_100); #1;
        end
    endtask

    task automatic test_reset();
        bus.flaga_d  = 1'b1;
        bus.flagb_d  = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.in_last  = 1'b0;
        enable       = 1'b1;
        idle_cycles(3);
        @(negedge clk_100); #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready: %b, required 0", bus.in_ready);
        end
        checks++;
        if (bus.slwr_out_ !== 1'b1 || bus.pktend_out_ !== 1'b1) begin
            errors++; $display("FAIL rst_strobes: slwr=%b pktend=%b, required 1 1", bus.slwr_out_, bus.pktend_out_);
        end
        checks++;
        if (bus.data_out !== 32'd0) begin
            errors++; $display("FAIL rst_data: %h, required 00000000", bus.data_out);
        end
        checks++;
        if (fifo_level !== 5'd0) begin
            errors++; $display("FAIL rst_level: %0d, required 0", fifo_level);
        end
        checks++;
        if (tx_word_cnt !== 32'd0 || tx_pkt_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_counters: %0d %0d, required 0 0", tx_word_cnt, tx_pkt_cnt);
        end
        @(posedge clk_100); #1;
        reset = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_basic_packet();
        clear_logs();
        for (int i = 1; i <= 4; i++) send(32'(i), (i == 4));
        for (int k = 0; k < 30 && obs_data.size() < 4; k++) begin
            @(negedge clk_100); #1;
        end
        checks++;
        if (obs_data.size() != 4) begin
            errors++; $display("FAIL basic_count: %0d writes, required 4", obs_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_data[i] !== 32'(i + 1) || obs_last[i] !== (i == 3) || obs_cyc[i] != obs_cyc[0] + i) begin
                    errors++;
                    $display("FAIL basic_word%0d: data=%h last=%b cycle+%0d, required data=%h last=%b cycle+%0d",
                             i, obs_data[i], obs_last[i], obs_cyc[i] - obs_cyc[0], 32'(i + 1), (i == 3), i);
                end
            end
        end
        @(posedge clk_100); #1;
    endtask

    task automatic test_backpressure();
        clear_logs();
        bus.flagb_d = 1'b0;
        for (int i = 0; i < 16; i++) send($urandom, (i == 9));
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        bus.in_last  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_100); #1;
            checks++;
            if (fifo_level !== 5'd16 || bus.in_ready !== 1'b0 || obs_data.size() != 0) begin
                errors++;
                $display("FAIL full_hold: level=%0d in_ready=%b writes=%0d, required 16 0 0",
                         fifo_level, bus.in_ready, obs_data.size());
            end
            @(posedge clk_100); #1;
        end
        bus.flagb_d = 1'b1;
        send(bus.in_data, 1'b0);
        for (int i = 17; i < 20; i++) send($urandom, (i == 19));
        for (int k = 0; k < 60 && obs_data.size() < 20; k++) begin
            @(negedge clk_100); #1;
        end
        checks++;
        if (obs_data.size() != 20 || sent_data.size() != 20) begin
            errors++; $display("FAIL wrap_count: %0d writes of %0d sent, required 20 of 20", obs_data.size(), sent_data.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (obs_data[i] !== sent_data[i]) begin
                    errors++; $display("FAIL wrap_order%0d: %h, required %h", i, obs_data[i], sent_data[i]);
                end
            end
        end
        @(posedge clk_100); #1;
    endtask

    task automatic test_flag_drop();
        int c_drop;
        int c_rise;
        int bad;
        clear_logs();
        for (int i = 0; i < 3; i++) send($urandom, 1'b0);
        bus.flagb_d = 1'b0;
        c_drop = cyc;
        for (int i = 3; i < 6; i++) send($urandom, 1'b0);
        idle_cycles(2);
        bus.flagb_d = 1'b1;
        c_rise = cyc;
        for (int i = 6; i < 8; i++) send($urandom, (i == 7));
        for (int k = 0; k < 40 && obs_data.size() < 8; k++) begin
            @(negedge clk_100); #1;
        end
        bad = 0;
        foreach (obs_cyc[i]) if (obs_cyc[i] >= c_drop + 2 && obs_cyc[i] <= c_rise + 1) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL drop_stall: %0d writes while flagb_d=0, required 0", bad);
        end
        checks++;
        if (obs_data.size() != 8) begin
            errors++; $display("FAIL drop_count: %0d writes, required 8", obs_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_data[i] !== sent_data[i]) begin
                    errors++; $display("FAIL drop_order%0d: %h, required %h", i, obs_data[i], sent_data[i]);
                end
            end
        end
        @(posedge clk_100); #1;
    endtask

    task automatic test_level_hold();
        bit reached;
        clear_logs();
        bus.flaga_d = 1'b0;
        for (int i = 0; i < 6; i++) send($urandom, 1'b0);
        bus.flaga_d = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 10 && !reached; k++) begin
            @(negedge clk_100); #1;
            if (fifo_level === 5'd5) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL hold_start: level=%0d, required 5 within 10 cycles", fifo_level);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        bus.in_last  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_100); #1;
            bus.in_data = $urandom;
            bus.in_last = ($urandom_range(0, 3) == 0);
            @(negedge clk_100); #1;
            checks++;
            if (fifo_level !== 5'd5) begin
                errors++; $display("FAIL hold_level%0d: %0d, required 5", k, fifo_level);
            end
        end
        @(posedge clk_100); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 40 && fifo_level !== 5'd0; k++) begin
            @(negedge clk_100); #1;
        end
        checks++;
        if (fifo_level !== 5'd0) begin
            errors++; $display("FAIL hold_drain: level=%0d, required 0", fifo_level);
        end
        @(posedge clk_100); #1;
    endtask

    task automatic test_enable_fall();
        clear_logs();
        bus.flaga_d = 1'b0;
        for (int i = 0; i < 6; i++) send($urandom, (i == 5));
        @(negedge clk_100); #1;
        checks++;
        if (fifo_level !== 5'd6) begin
            errors++; $display("FAIL en_fill: level=%0d, required 6", fifo_level);
        end
        @(posedge clk_100); #1;
        enable      = 1'b0;
        bus.flaga_d = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL en_ready: in_ready=%b, required 0", bus.in_ready);
        end
        @(posedge clk_100); #1;
        @(negedge clk_100); #1;
        checks++;
        if (fifo_level !== 5'd0) begin
            errors++; $display("FAIL en_flush: level=%0d, required 0", fifo_level);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_100); #1;
            checks++;
            if (bus.slwr_out_ !== 1'b1) begin
                errors++; $display("FAIL en_quiet%0d: slwr=%b, required 1", k, bus.slwr_out_);
            end
        end
`ifdef STREAMIN_BUF_CNT_EN
        checks++;
        if (tx_word_cnt !== words_wr || tx_pkt_cnt !== pkts_wr) begin
            errors++; $display("FAIL en_counters: %0d %0d, required %0d %0d", tx_word_cnt, tx_pkt_cnt, words_wr, pkts_wr);
        end
`else
        checks++;
        if (tx_word_cnt !== 32'd0 || tx_pkt_cnt !== 16'd0) begin
            errors++; $display("FAIL en_counters_off: %0d %0d, required 0 0", tx_word_cnt, tx_pkt_cnt);
        end
`endif
        @(posedge clk_100); #1;
        enable = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_packet();
        bit lastseen;
        clear_logs();
        bus.flaga_d = 1'b0;
        for (int i = 0; i < 5; i++) send($urandom, (i == 4));
        bus.flaga_d = 1'b1;
        for (int k = 0; k < 10 && obs_data.size() == 0; k++) begin
            @(negedge clk_100); #1;
        end
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        @(negedge clk_100); #1;
        checks++;
        if (fifo_level !== 5'd0) begin
            errors++; $display("FAIL midrst_level: %0d, required 0", fifo_level);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_100); #1;
        end
        lastseen = 1'b0;
        foreach (obs_last[i]) if (obs_last[i]) lastseen = 1'b1;
        checks++;
        if (obs_data.size() >= 5 || lastseen) begin
            errors++; $display("FAIL midrst_discard: %0d writes pktend_seen=%b, required <5 writes and no pktend",
                               obs_data.size(), lastseen);
        end
        @(posedge clk_100); #1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            enable       = ($urandom_range(0, 39) != 0);
            bus.flaga_d  = ($urandom_range(0, 7) != 0);
            bus.flagb_d  = ($urandom_range(0, 5) != 0);
            bus.in_valid = $urandom_range(0, 1);
            bus.in_data  = $urandom;
            bus.in_last  = ($urandom_range(0, 4) == 0);
            @(posedge clk_100); #1;
        end
        enable       = 1'b1;
        bus.flaga_d  = 1'b1;
        bus.flagb_d  = 1'b1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 60 && (fifo_level !== 5'd0 || mq.size() != 0); k++) begin
            @(negedge clk_100); #1;
        end
        checks++;
        if (fifo_level !== 5'd0 || mq.size() != 0) begin
            errors++; $display("FAIL random_drain: level=%0d model=%0d, required 0 0", fifo_level, mq.size());
        end
        @(posedge clk_100); #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.in_last  = 1'b0;
        bus.flaga_d  = 1'b1;
        bus.flagb_d  = 1'b1;
        @(posedge clk_100); #1;
        test_reset();
        test_basic_packet();
        test_backpressure();
        test_flag_drop();
        test_level_hold();
        test_enable_fall();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1);
    end

endmodule
